// File: rtl/rom_fetch_pkg.sv
// Shared definitions for the 128x32 ROM fetch engine: geometry, FSM state
// type and the burst-code to beat-count decode.
package rom_fetch_pkg;

  localparam int ROM_AW = 7;
  localparam int ROM_DW = 32;
  localparam int BEAT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  // Burst code 0..3 selects 1, 2, 4 or 8 beats.
  function automatic logic [BEAT_W-1:0] len_to_beats(input logic [1:0] len);
    logic [BEAT_W-1:0] beats;
    beats = 4'd1 << len;
    return beats;
  endfunction

endpackage

// File: rtl/rom_fetch_fifo2.sv
// Two-entry response FIFO holding {last, data}. A push and a pop in the same
// cycle are both honoured, including at full occupancy.
module rom_fetch_fifo2
  import rom_fetch_pkg::*;
#(
  parameter int W = ROM_DW + 1
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem0;
  logic [W-1:0] r_mem1;
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push_ok;
  logic         w_pop_ok;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = r_rd_ptr ? r_mem1 : r_mem0;

  // Storage, pointers and occupancy; contents reset to zero so the head reads 0.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem0   <= '0;
      r_mem1   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        if (r_wr_ptr) r_mem1 <= i_data;
        else          r_mem0 <= i_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop_ok) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rom_fetch_128x32.sv
// Burst fetch engine in front of a 128x32 synchronous ROM. Issues at most one
// read per cycle, limited so buffered plus in-flight words never exceed two.
// Build option ROM_FETCH_BURST_EN: when defined ReqLen selects 1/2/4/8 beats;
// otherwise every request is a single beat.
module rom_fetch_128x32
  import rom_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [ROM_AW-1:0] ReqAdr,
  input  logic [1:0]        ReqLen,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [ROM_DW-1:0] RspData,
  output logic              RspLast,
  output logic              RomCEB,
  output logic [ROM_AW-1:0] RomA,
  input  logic [ROM_DW-1:0] RomQ
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ROM_AW-1:0] r_addr;
  logic [ROM_AW-1:0] r_a_hold;
  logic [BEAT_W-1:0] r_beats;
  logic [BEAT_W-1:0] w_req_beats;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              w_accept;
  logic              w_issue;
  logic              w_credit;
  logic              w_pop;
  logic              w_last_issue;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [1:0]        w_occ;
  logic [1:0]        w_pending;
  logic [ROM_DW:0]   w_fifo_q;

  assign ReqReady = (r_state == ST_IDLE) && reset_n;
  assign w_accept = ReqValid && ReqReady;

`ifdef ROM_FETCH_BURST_EN
  assign w_req_beats = len_to_beats(ReqLen);
`else
  // Single-beat build: the burst code is masked so every request decodes to 1.
  assign w_req_beats = len_to_beats(ReqLen & 2'b00);
`endif

  assign w_occ        = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);
  assign w_pending    = w_occ + {1'b0, r_inflight};
  assign w_pop        = RspValid && RspReady;
  assign w_credit     = (w_pending < 2'd2) || ((w_pending == 2'd2) && w_pop);
  assign w_last_issue = w_issue && (r_beats == 4'd1);

  // Issued address drives the ROM; otherwise the last issued address is held.
  assign RomCEB = !w_issue;
  assign RomA   = w_issue ? r_addr : r_a_hold;

  assign RspValid = !w_fifo_empty;
  assign RspLast  = w_fifo_q[ROM_DW];
  assign RspData  = w_fifo_q[ROM_DW-1:0];

  // Next-state and read-issue decode.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        w_issue = w_credit;
        if (w_issue && (r_beats == 4'd1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Address/beat bookkeeping and the one-deep in-flight tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr          <= '0;
      r_a_hold        <= '0;
      r_beats         <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= ReqAdr;
        r_beats <= w_req_beats;
      end else if (w_issue) begin
        r_addr   <= r_addr + 7'd1;
        r_beats  <= r_beats - 4'd1;
        r_a_hold <= r_addr;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
    end
  end

  rom_fetch_fifo2 #(.W(ROM_DW + 1)) u_fifo (
    .clk     (clk),
    .i_rst_n (reset_n),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  ({r_inflight_last, RomQ}),
    .o_data  (w_fifo_q),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: doc/rom_fetch_128x32.md
ROM_FETCH_128X32 -- requirements
Module: rom_fetch_128x32

Interface
REQ-001 Parameters: none; geometry fixed by package constants ROM_AW=7, ROM_DW=32.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ReqValid  in  1  fetch request present.
REQ-005 ReqReady  out  1  request accepted when ReqValid&ReqReady at rising edge.
REQ-006 ReqAdr  in  7  start word address.
REQ-007 ReqLen  in  2  burst code: 0=1, 1=2, 2=4, 3=8 beats.
REQ-008 RspValid  out  1  RspData/RspLast valid.
REQ-009 RspReady  in  1  consumer takes beat when RspValid&RspReady at rising edge.
REQ-010 RspData  out  32  ROM word.
REQ-011 RspLast  out  1  final beat of current request.
REQ-012 RomCEB  out  1  ROM chip enable, active-low, to 128x32 ROM wrapper CEB.
REQ-013 RomA  out  7  ROM address, to wrapper A.
REQ-014 RomQ  in  32  ROM data, valid one cycle after RomCEB low.

Function
REQ-015 FSM states IDLE, READ; ReqReady = (state==IDLE) and reset_n high.
REQ-016 IDLE: on accept, latch ReqAdr as next address, beats remaining = decoded length, go READ.
REQ-017 READ: issue read (RomCEB=0, RomA=next address) only when credit ok; otherwise RomCEB=1, RomA holds last value.
REQ-018 Credit ok: FIFO occupancy + in-flight reads < 2, or == 2 with a FIFO pop in the same cycle.
REQ-019 Each issue increments address modulo 128 (127 wraps to 0) and decrements beats remaining.
REQ-020 Issue of final beat: return to IDLE next cycle; the final beat is tagged last in flight.
REQ-021 RomQ sampled into 2-entry FIFO with its last tag at end of cycle following issue.
REQ-022 RspValid = FIFO non-empty; RspData/RspLast = FIFO head; pop on RspValid&RspReady.
REQ-023 Latency: accept at end of cycle 0 -> RomCEB low cycle 1 -> RspValid cycle 3 minimum.
REQ-024 Throughput: one beat per cycle sustained while RspReady held high.
REQ-025 RspReady low: at most 2 reads outstanding+buffered; no beat dropped, duplicated or reordered.
REQ-026 New request accepted in IDLE while FIFO still drains previous beats; ordering preserved.
REQ-027 Simultaneous FIFO push and pop at occupancy 2 or 1 is legal; occupancy unchanged.
REQ-028 ReqAdr/ReqLen ignored when not accepted; no speculative ROM reads in IDLE.

Reset
REQ-029 reset_n low asynchronously: state IDLE, FIFO empty, in-flight tag cleared, RomCEB=1, RomA=0, RspValid=0, RspLast=0, RspData=0, ReqReady=0.
REQ-030 Reset mid-burst discards all pending and in-flight beats; first cycle after release ReqReady=1.

Configuration
REQ-031 Macro ROM_FETCH_BURST_EN defined: ReqLen decoded per REQ-007.
REQ-032 Macro undefined: ReqLen port present but ignored; every request is 1 beat; RspLast always 1 with RspValid.

Structure
REQ-033 Package rom_fetch_pkg: ROM_AW, ROM_DW, state enum type, ReqLen-to-beat-count decode function.
REQ-034 Sub-module rom_fetch_fifo2: 2-entry 33-bit FIFO (data+last), async active-low reset, push/pop/full/empty.

Verification
REQ-035 Single: ROM[0x05]=0xDEADBEEF, Req adr 0x05 len 0, RspReady=1 -> RomCEB low cycle 1 with RomA=0x05; RspValid cycle 3, data 0xDEADBEEF, RspLast=1.
REQ-036 Wrap burst (BURST_EN): adr 0x7E len 2 -> RomA sequence 0x7E,0x7F,0x00,0x01 on consecutive cycles; 4 beats, RspLast only on 4th.
REQ-037 Backpressure: adr 0x10 len 3, RspReady low cycles 3-10 -> at most 2 reads issued before stall; after release 8 beats ROM[0x10..0x17] in order, no gaps once resumed.
REQ-038 Back-to-back: two requests (0x20 len 1, 0x40 len 0) -> second accepted in IDLE after first issues; beats 0x20,0x21,0x40; RspLast on 0x21 and 0x40.
REQ-039 Reset mid-burst: reset_n low during beat 3 of 8-beat burst -> RspValid, RomCEB=1 immediately; after release FIFO empty, ReqReady=1, new single read returns correct word.
REQ-040 No BURST_EN: adr 0x03 len 3 -> exactly one ROM read, one beat, RspLast=1.
